bus_region_decoder: RTL
=======================

BUS_REGION_DECODER -- requirements
Module: bus_region_decoder

Interface
REQ-001 SHALL have parameter ADDR_W, default 20, meaning CPU address width.
REQ-002 SHALL have parameter DATA_W, default 8, meaning data bus width.
REQ-003 SHALL have parameter NREG, default 4, meaning number of decoded regions (1..16).
REQ-004 SHALL have parameter PAGE_W, default 8, meaning number of upper address bits compared (ADDR_W-1 down to ADDR_W-PAGE_W).
REQ-005 SHALL have parameter REG_BASE, default all-zero NREG*PAGE_W vector, meaning per-region page base; region i occupies slice [i*PAGE_W +: PAGE_W].
REQ-006 SHALL have parameter REG_MASK, default all-ones NREG*PAGE_W vector, meaning per-region compare mask; a 1 bit is compared.
REQ-007 SHALL have parameter REG_WAIT, default all-zero NREG*4 vector, meaning per-region wait states, 0..15.
REQ-008 SHALL have parameter UNMAPPED_DATA, default all-ones DATA_W, meaning read data returned on a decode miss.
REQ-009 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-010 SHALL have port reset, input, 1, meaning synchronous active-high reset.
REQ-011 SHALL have port cpu_addr, input, ADDR_W, meaning access address.
REQ-012 SHALL have port cpu_req, input, 1, meaning access request, held until cpu_ready.
REQ-013 SHALL have port cpu_we, input, 1, meaning 1 = write, 0 = read.
REQ-014 SHALL have port cpu_wdata, input, DATA_W, meaning write data.
REQ-015 SHALL have port cpu_rdata, output, DATA_W, meaning read data, valid while cpu_ready=1.
REQ-016 SHALL have port cpu_ready, output, 1, meaning one-cycle access-complete pulse.
REQ-017 SHALL have port cpu_err, output, 1, meaning decode miss, valid with cpu_ready.
REQ-018 SHALL have port dev_cs, output, NREG, meaning registered one-hot region select.
REQ-019 SHALL have port dev_we, output, 1, meaning registered write strobe, qualified by dev_cs.
REQ-020 SHALL have port dev_addr, output, ADDR_W, meaning registered access address.
REQ-021 SHALL have port dev_wdata, output, DATA_W, meaning registered write data.
REQ-022 SHALL have port dev_rdata, input, NREG*DATA_W, meaning per-region read data, slice i per region.
REQ-023 SHALL have port dev_rdy, input, NREG, meaning per-region ready; 0 extends the access.

Function
REQ-024 SHALL define hit(i) = ((cpu_addr[ADDR_W-1 -: PAGE_W] ^ REG_BASE_i) & REG_MASK_i) == 0; lowest matching index wins.
REQ-025 SHALL implement states IDLE, ACCESS, MISS.
REQ-026 SHALL, in IDLE with cpu_req=1 and a hit on region r, go to ACCESS, latch r, load wait counter with REG_WAIT_r, register dev_addr/dev_we/dev_wdata, and set dev_cs = one-hot(r).
REQ-027 SHALL, in IDLE with cpu_req=1 and no hit, go to MISS with dev_cs = 0.
REQ-028 SHALL, in ACCESS, decrement the counter while nonzero; when the counter is 0 and dev_rdy[r]=1, pulse cpu_ready for that cycle and return to IDLE.
REQ-029 SHALL give minimum latency: req sampled at edge N, dev_cs high from N+1, cpu_ready high in cycle N+1+REG_WAIT_r, plus one cycle per cycle dev_rdy[r]=0 at counter 0.
REQ-030 SHALL drive cpu_rdata = dev_rdata slice of the latched region during ACCESS, and cpu_err = 0.
REQ-031 SHALL, in MISS, pulse cpu_ready for one cycle with cpu_err=1 and cpu_rdata=UNMAPPED_DATA, then return to IDLE; a write miss is discarded.
REQ-032 SHALL clear dev_cs and dev_we on the edge that leaves ACCESS.
REQ-033 SHALL ignore cpu_addr, cpu_we and cpu_wdata changes outside IDLE.
REQ-034 SHALL start a new access in the cycle after cpu_ready when cpu_req is still 1 (back-to-back, one IDLE cycle between accesses).
REQ-035 SHALL drive cpu_ready=0, cpu_err=0 and cpu_rdata=0 whenever not completing.

Reset
REQ-036 SHALL, on reset=1 at any edge including mid-access, enter IDLE with dev_cs=0, dev_we=0, cpu_ready=0, cpu_err=0, counter=0, dev_addr=0, dev_wdata=0; an interrupted access does not complete.

Verification
REQ-037 SHALL cover region 0 base 8'h0E, mask 8'hFE, wait 0: read 20'hE123 -> dev_cs=4'b0001 at N+1, cpu_ready at N+1, cpu_rdata = dev_rdata slice 0.
REQ-038 SHALL cover region 2 wait 3: write 20'h80010 data 8'hA5 -> dev_cs=4'b0100, dev_we=1 for 4 cycles, cpu_ready at N+4, dev_wdata=8'hA5.
REQ-039 SHALL cover overlapping regions 1 and 3 both matching 20'hD040 -> dev_cs=4'b0010 (priority).
REQ-040 SHALL cover unmapped 20'h10000 read -> cpu_ready at N+1, cpu_err=1, cpu_rdata=8'hFF, dev_cs=0 throughout.
REQ-041 SHALL cover dev_rdy[1] held 0 for 5 cycles at counter 0 -> cpu_ready delayed exactly 5 cycles.
REQ-042 SHALL cover reset asserted in cycle 2 of a wait-5 access -> no cpu_ready pulse, dev_cs=0 next cycle, a following request completes normally.

Source files
------------

// File: rtl/bus_region_decoder.sv
// Page-based address decoder that steers one CPU access at a time to one of NREG device
// regions, inserting per-region wait states and answering unmapped accesses itself.
module bus_region_decoder #(
   parameter int                      ADDR_W        = 20,
   parameter int                      DATA_W        = 8,
   parameter int                      NREG          = 4,
   parameter int                      PAGE_W        = 8,
   parameter logic [NREG*PAGE_W-1:0]  REG_BASE      = '0,
   parameter logic [NREG*PAGE_W-1:0]  REG_MASK      = '1,
   parameter logic [NREG*4-1:0]       REG_WAIT      = '0,
   parameter logic [DATA_W-1:0]       UNMAPPED_DATA = '1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [ADDR_W-1:0]        cpu_addr,
   input  logic                     cpu_req,
   input  logic                     cpu_we,
   input  logic [DATA_W-1:0]        cpu_wdata,
   output logic [DATA_W-1:0]        cpu_rdata,
   output logic                     cpu_ready,
   output logic                     cpu_err,
   output logic [NREG-1:0]          dev_cs,
   output logic                     dev_we,
   output logic [ADDR_W-1:0]        dev_addr,
   output logic [DATA_W-1:0]        dev_wdata,
   input  logic [NREG*DATA_W-1:0]   dev_rdata,
   input  logic [NREG-1:0]          dev_rdy
);

   localparam int IDX_W = (NREG > 1) ? $clog2(NREG) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      MISS   = 2'd2
   } state_t;

   state_t             state;
   logic [IDX_W-1:0]   cur;
   logic [3:0]         cnt;

   logic [PAGE_W-1:0]  page;
   logic               hit_any;
   logic [IDX_W-1:0]   hit_idx;
   logic [NREG-1:0]    hit_onehot;
   logic               done_access;

   assign page = cpu_addr[ADDR_W-1 -: PAGE_W];

   // Scan from the top down so the lowest matching region is the one left standing.
   always_comb begin
      hit_any    = 1'b0;
      hit_idx    = '0;
      hit_onehot = '0;
      for (int i = NREG - 1; i >= 0; i--) begin
         if (((page ^ REG_BASE[i*PAGE_W +: PAGE_W]) & REG_MASK[i*PAGE_W +: PAGE_W]) == '0) begin
            hit_any = 1'b1;
            hit_idx = IDX_W'(i);
         end
      end
      hit_onehot[hit_idx] = hit_any;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cur       <= '0;
         cnt       <= '0;
         dev_cs    <= '0;
         dev_we    <= 1'b0;
         dev_addr  <= '0;
         dev_wdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cpu_req) begin
                  if (hit_any) begin
                     state     <= ACCESS;
                     cur       <= hit_idx;
                     cnt       <= REG_WAIT[hit_idx*4 +: 4];
                     dev_cs    <= hit_onehot;
                     dev_we    <= cpu_we;
                     dev_addr  <= cpu_addr;
                     dev_wdata <= cpu_wdata;
                  end else begin
                     state  <= MISS;
                     dev_cs <= '0;
                  end
               end
            end
            ACCESS: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else if (dev_rdy[cur]) begin
                  state  <= IDLE;
                  dev_cs <= '0;
                  dev_we <= 1'b0;
               end
            end
            MISS: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Completion depends on the device's ready in the same cycle, so it stays combinational.
   assign done_access = (state == ACCESS) && (cnt == 4'd0) && dev_rdy[cur];

   always_comb begin
      cpu_ready = 1'b0;
      cpu_err   = 1'b0;
      cpu_rdata = '0;
      if (done_access) begin
         cpu_ready = 1'b1;
         cpu_rdata = dev_rdata[cur*DATA_W +: DATA_W];
      end else if (state == MISS) begin
         cpu_ready = 1'b1;
         cpu_err   = 1'b1;
         cpu_rdata = UNMAPPED_DATA;
      end
   end

endmodule
